// File: rtl/rb_pkg.sv
// Shared constants and helpers for the readback multiplexer.
package rb_pkg;

  localparam int unsigned RB_WORD_W  = 32;
  localparam int unsigned TORN_CNT_W = 8;

  // Ceiling log2, usable in parameter context.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rb_shadow_reg.sv
// Shadow copy of one readback word, tagged with its index, for coherent 16-bit upper reads.
module rb_shadow_reg
  import rb_pkg::*;
#(
  parameter int unsigned IdxW = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 capture_i,
  input  logic                 clear_i,
  input  logic [RB_WORD_W-1:0] word_i,
  input  logic [IdxW-1:0]      idx_i,
  output logic                 hit_o,
  output logic [RB_WORD_W-1:0] shadow_o
);

  logic [RB_WORD_W-1:0] shadow_q;
  logic [IdxW-1:0]      tag_q;
  logic                 valid_q, valid_d;

  always_comb begin
    valid_d = valid_q;
    if (capture_i) begin
      valid_d = 1'b1;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Data and tag are meaningless while valid is low, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (capture_i) begin
      shadow_q <= word_i;
      tag_q    <= idx_i;
    end
  end

  assign hit_o    = valid_q && (tag_q == idx_i);
  assign shadow_o = shadow_q;

endmodule

// File: rtl/wb_readback_mux_shadow.sv
// Wishbone readback mux for NWORDS status words on a 16- or 32-bit bus; in 16-bit mode a lower
// read snapshots the word so the following upper read is coherent, and uncaptured uppers are counted.
module wb_readback_mux_shadow
  import rb_pkg::*;
#(
  parameter int unsigned DW     = 16,
  parameter int unsigned NWORDS = 16,
  parameter int unsigned AW     = 16
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          wb_stb_i,
  input  logic                          wb_we_i,
  input  logic [AW-1:0]                 wb_adr_i,
  output logic [DW-1:0]                 wb_dat_o,
  output logic                          wb_ack_o,
  input  logic [RB_WORD_W*NWORDS-1:0]   words_i,
  output logic [TORN_CNT_W-1:0]         torn_cnt_o
);

  localparam int unsigned IdxW = clog2(NWORDS);

  logic [IdxW-1:0]       idx;
  logic [RB_WORD_W-1:0]  word;
  logic                  ack_q, ack_next;
  logic                  rd;
  logic [DW-1:0]         dat_q, dat_d;
  logic [TORN_CNT_W-1:0] torn_q, torn_d;
  logic                  unused_adr;

  // Higher address bits are deliberately ignored so addresses alias.
  assign unused_adr = ^wb_adr_i;

  assign idx      = wb_adr_i[IdxW+1:2];
  assign word     = words_i[idx*RB_WORD_W +: RB_WORD_W];
  assign ack_next = wb_stb_i & ~ack_q;
  assign rd       = ack_next & ~wb_we_i;

  if (DW == 16) begin : g_dw16
    logic                 capture, clear, hit;
    logic [RB_WORD_W-1:0] shadow;

    rb_shadow_reg #(
      .IdxW (IdxW)
    ) u_shadow (
      .clk_i     (wb_clk_i),
      .rst_i     (wb_rst_i),
      .capture_i (capture),
      .clear_i   (clear),
      .word_i    (word),
      .idx_i     (idx),
      .hit_o     (hit),
      .shadow_o  (shadow)
    );

    always_comb begin
      dat_d   = dat_q;
      torn_d  = torn_q;
      capture = 1'b0;
      clear   = 1'b0;
      if (rd) begin
        if (!wb_adr_i[1]) begin
          capture = 1'b1;
          dat_d   = word[15:0];
        end else if (hit) begin
          clear = 1'b1;
          dat_d = shadow[31:16];
        end else begin
          dat_d = word[31:16];
          if (torn_q != '1) begin
            torn_d = torn_q + 1'b1;
          end
        end
      end
    end
  end else begin : g_dw32
    always_comb begin
      dat_d  = dat_q;
      torn_d = torn_q;
      if (rd) begin
        dat_d = word[DW-1:0];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      torn_q <= '0;
    end else begin
      ack_q  <= ack_next;
      dat_q  <= dat_d;
      torn_q <= torn_d;
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign torn_cnt_o = torn_q;

endmodule

// File: tb/tb_wb_readback_mux_shadow.sv
// Directed scoreboard bench: a 16-bit/16-word instance and a 32-bit/64-word instance.
module tb_wb_readback_mux_shadow;

  typedef struct packed {
    logic [31:0] dat;
    logic [7:0]  torn;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            stb16 = 1'b0, we16 = 1'b0;
  logic [15:0]     adr16 = '0;
  logic [15:0]     dat16;
  logic            ack16;
  logic [7:0]      torn16;
  logic [32*16-1:0] w16 = '0;

  logic            stb32 = 1'b0, we32 = 1'b0;
  logic [15:0]     adr32 = '0;
  logic [31:0]     dat32;
  logic            ack32;
  logic [7:0]      torn32;
  logic [32*64-1:0] w32 = '0;

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t sb[$];

  wb_readback_mux_shadow #(.DW(16), .NWORDS(16), .AW(16)) dut16 (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb_stb_i   (stb16),
    .wb_we_i    (we16),
    .wb_adr_i   (adr16),
    .wb_dat_o   (dat16),
    .wb_ack_o   (ack16),
    .words_i    (w16),
    .torn_cnt_o (torn16)
  );

  wb_readback_mux_shadow #(.DW(32), .NWORDS(64), .AW(16)) dut32 (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb_stb_i   (stb32),
    .wb_we_i    (we32),
    .wb_adr_i   (adr32),
    .wb_dat_o   (dat32),
    .wb_ack_o   (ack32),
    .words_i    (w32),
    .torn_cnt_o (torn32)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [7:0] t);
    exp_t e;
    e.dat  = d;
    e.torn = t;
    sb.push_back(e);
  endtask

  // One 16-bit access: drive on a falling edge, expect ack and data one cycle later.
  task automatic access16(input logic [15:0] adr, input logic we, input logic [15:0] ed,
                          input logic [7:0] et);
    exp_t e;
    push_exp({16'h0, ed}, et);
    stb16 = 1'b1;
    we16  = we;
    adr16 = adr;
    @(negedge clk);
    chk("ack16", {31'h0, ack16}, 32'h1);
    e = sb.pop_front();
    chk("dat16", {16'h0, dat16}, e.dat);
    chk("torn16", {24'h0, torn16}, {24'h0, e.torn});
    stb16 = 1'b0;
    we16  = 1'b0;
    @(negedge clk);
    chk("ack16_idle", {31'h0, ack16}, 32'h0);
  endtask

  initial begin
    exp_t e;
    int   exp_torn;

    repeat (2) @(negedge clk);
    chk("rst_ack16", {31'h0, ack16}, 32'h0);
    chk("rst_dat16", {16'h0, dat16}, 32'h0);
    chk("rst_torn16", {24'h0, torn16}, 32'h0);
    chk("rst_ack32", {31'h0, ack32}, 32'h0);
    chk("rst_dat32", dat32, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Coherent lower/upper pair.
    w16[3*32 +: 32] = 32'hDEADBEEF;
    access16(16'h000C, 1'b0, 16'hBEEF, 8'd0);
    access16(16'h000E, 1'b0, 16'hDEAD, 8'd0);

    // Word changes between halves; second upper read is torn.
    w16[3*32 +: 32] = 32'h11112222;
    access16(16'h000C, 1'b0, 16'h2222, 8'd0);
    w16[3*32 +: 32] = 32'h33334444;
    access16(16'h000E, 1'b0, 16'h1111, 8'd0);
    access16(16'h000E, 1'b0, 16'h3333, 8'd1);

    // Upper read of a different index is torn and keeps the shadow.
    w16[2*32 +: 32] = 32'hCAFEF00D;
    w16[5*32 +: 32] = 32'hAAAA5555;
    access16(16'h0008, 1'b0, 16'hF00D, 8'd1);
    access16(16'h0016, 1'b0, 16'hAAAA, 8'd2);
    w16[2*32 +: 32] = 32'h12345678;
    access16(16'h000A, 1'b0, 16'hCAFE, 8'd2);

    // Write between lower and upper: acked, data held, shadow still hits.
    access16(16'h000C, 1'b0, 16'h4444, 8'd2);
    access16(16'h000E, 1'b1, 16'h4444, 8'd2);
    w16[3*32 +: 32] = 32'h55556666;
    access16(16'h000E, 1'b0, 16'h3333, 8'd2);

    // Aliased index bits above the word field.
    access16(16'h004C, 1'b0, 16'h6666, 8'd2);
    access16(16'h000E, 1'b0, 16'h5555, 8'd2);

    // Saturation of the torn counter.
    exp_torn = 2;
    for (int i = 0; i < 300; i++) begin
      if (exp_torn < 255) exp_torn++;
      access16(16'h0016, 1'b0, 16'hAAAA, exp_torn[7:0]);
    end
    chk("torn_sat", {24'h0, torn16}, 32'd255);

    // Reset with a pending access: access lost, counter cleared.
    stb16 = 1'b1;
    adr16 = 16'h0016;
    rst   = 1'b1;
    @(negedge clk);
    chk("rst_pend_ack", {31'h0, ack16}, 32'h0);
    chk("rst_pend_torn", {24'h0, torn16}, 32'h0);
    chk("rst_pend_dat", {16'h0, dat16}, 32'h0);
    rst   = 1'b0;
    stb16 = 1'b0;
    @(negedge clk);
    access16(16'h0016, 1'b0, 16'hAAAA, 8'd1);

    // 32-bit instance: held strobe gives ack every other cycle.
    w32[63*32 +: 32] = 32'h01234567;
    w32[62*32 +: 32] = 32'h89ABCDEF;
    adr32 = 16'h00FC;
    stb32 = 1'b1;
    push_exp(32'h01234567, 8'd0);
    push_exp(32'h01234567, 8'd0);
    chk("ack32_c0", {31'h0, ack32}, 32'h0);
    @(negedge clk);
    chk("ack32_c1", {31'h0, ack32}, 32'h1);
    e = sb.pop_front();
    chk("dat32_a", dat32, e.dat);
    @(negedge clk);
    chk("ack32_c2", {31'h0, ack32}, 32'h0);
    chk("dat32_hold", dat32, 32'h01234567);
    @(negedge clk);
    chk("ack32_c3", {31'h0, ack32}, 32'h1);
    e = sb.pop_front();
    chk("dat32_b", dat32, e.dat);
    chk("torn32", {24'h0, torn32}, {24'h0, e.torn});
    stb32 = 1'b0;
    @(negedge clk);
    // Half-select bit has no effect at DW=32.
    adr32 = 16'h00FA;
    stb32 = 1'b1;
    @(negedge clk);
    chk("ack32_d", {31'h0, ack32}, 32'h1);
    chk("dat32_c", dat32, 32'h89ABCDEF);
    chk("torn32_b", {24'h0, torn32}, 32'h0);
    stb32 = 1'b0;
    @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_readback_mux_shadow.md
# wb_readback_mux_shadow

Parametrised Wishbone readback multiplexer that presents NWORDS 32-bit status words to a 16- or 32-bit slave bus. In 16-bit mode, reading a lower half captures the whole 32-bit word into a shadow register, so the following upper-half read is coherent. Upper-half reads with no matching capture are counted as torn reads. It sits on the settings/readback Wishbone segment alongside the other control-lib slaves, all on the same clock.

## Interface
- DW, 16: bus data width; legal values 16 or 32.
- NWORDS, 16: number of readback words; power of 2, 2..64.
- AW, 16: width of wb_adr_i; must be ≥ log2(NWORDS)+2.
- wb_clk_i  in  1  sole clock; all state on rising edge.
- wb_rst_i  in  1  reset; synchronous, active-high.
- wb_stb_i  in  1  strobe; cycle qualifier.
- wb_we_i  in  1  write enable; writes are acked and otherwise ignored.
- wb_adr_i  in  AW  byte address; word index = adr[log2(NWORDS)+1:2], half select = adr[1] (DW=16 only).
- wb_dat_o  out  DW  registered read data.
- wb_ack_o  out  1  single-cycle acknowledge.
- words_i  in  32*NWORDS  flat word vector; word k = words_i[32k+31:32k].
- torn_cnt_o  out  8  saturating count of uncaptured upper-half reads.

## Operation
- ack_next = wb_stb_i & ~wb_ack_o; wb_ack_o <= ack_next. All data and state updates happen only on ack_next & ~wb_we_i.
- Index bits above log2(NWORDS)+1 are ignored, so addresses alias.
- DW=32: wb_dat_o <= word[idx]. Shadow and torn counter are unused: valid stays 0 and torn_cnt_o stays 0.
- DW=16, adr[1]=0 (lower):
  - shadow <= word[idx]; shadow_idx <= idx; shadow_valid <= 1.
  - wb_dat_o <= word[idx][15:0].
- DW=16, adr[1]=1 (upper), with shadow_valid & shadow_idx==idx:
  - wb_dat_o <= shadow[31:16]; shadow_valid <= 0.
- DW=16, adr[1]=1, otherwise (torn):
  - wb_dat_o <= live word[idx][31:16].
  - torn_cnt_o increments, saturating at 255.
  - shadow_valid unchanged.
- A lower read to a different index overwrites the shadow. The last lower read always wins.
- Write cycles are acked one cycle after stb, exactly like reads. They leave wb_dat_o, shadow, shadow_valid and torn_cnt_o unchanged.
- wb_dat_o holds its value between accesses.

## Timing
- Reset values: wb_ack_o=0, wb_dat_o=0, shadow_valid=0, torn_cnt_o=0. The shadow contents are don't-care.
- Latency: wb_ack_o is high in the cycle after wb_stb_i is first seen. wb_dat_o is valid in that same cycle.
- A continuously held stb gives ack on alternate cycles: 1 access per 2 clocks.
- If stb drops during the ack cycle, there is no further ack. The slave has no wait states and never errors.
- Reset asserted with stb high and ack pending: ack=0 in the next cycle, the access is lost, and no counter update occurs.
- Reset has priority over all updates in the same cycle.
- A word changing on words_i between the lower and upper reads does not affect the upper value returned from the shadow.
- torn_cnt_o updates in the same cycle as the ack of the torn read.

## Structure
- Shared package `rb_pkg` holds:
  - RB_WORD_W = 32;
  - TORN_CNT_W = 8;
  - function clog2 for index width.
- Sub-module `rb_shadow_reg` holds the shadow word, tag, valid bit and hit compare, and outputs a hit flag. The top level holds ack generation, the mux, the output register and the saturating counter.
- Word select uses an indexed part-select on words_i, not an enumerated case, so it scales with NWORDS.

## Test plan
- DW=16, NWORDS=16. Set word3=0xDEADBEEF, read adr 0x0C then 0x0E → dat 0xBEEF then 0xDEAD, torn_cnt_o=0.
- DW=16. Read 0x0C (word3=0x11112222), change word3 to 0x33334444, read 0x0E → 0x1111, torn_cnt_o=0. Read 0x0E again → 0x3333, torn_cnt_o=1.
- DW=16. Read lower of word2, then upper of word5 (0xAAAA5555) → 0xAAAA, torn=1. Then upper of word2 → shadow upper, torn=1.
- DW=16. 300 consecutive torn upper reads → torn_cnt_o stops at 255. Then assert reset → 0, with wb_ack_o=0 the next cycle.
- DW=32, NWORDS=64. Read adr 0xFC (word63=0x01234567) with stb held → ack pattern 0,1,0,1; dat 0x01234567; torn_cnt_o stays 0.
- Write cycle to 0x0E between a lower read and an upper read → acked; the following upper read still hits the shadow; wb_dat_o is unchanged during the write ack.
